// File: rtl/ttc_counter_lite28.sv
// rtl/ttc_counter_lite28.sv - single timer-counter stage with interval, match, overflow and restart pulses
module ttc_counter_lite28 #(
    parameter int WIDTH = 16
) (
    input  logic             pclk28,
    input  logic             p_reset28,
    input  logic [WIDTH-1:0] pwdata28,
    input  logic             cntr_ctrl_reg_sel28,
    input  logic             interval_reg_sel28,
    input  logic [2:0]       match_reg_sel28,
    input  logic             count_en28,
    output logic [WIDTH-1:0] counter_val_out28,
    output logic [4:0]       cntr_ctrl_reg_out28,
    output logic [WIDTH-1:0] interval_reg_out28,
    output logic [WIDTH-1:0] match_1_reg_out28,
    output logic [WIDTH-1:0] match_2_reg_out28,
    output logic [WIDTH-1:0] match_3_reg_out28,
    output logic             interval_intr28,
    output logic [3:1]       match_intr28,
    output logic             overflow_intr28,
    output logic             restart28
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    // ctrl[4] (restart) is never stored; only bits [3:0] are held
    logic [3:0]       ctrl_q, ctrl_d;
    logic [WIDTH-1:0] counter_q, counter_d;
    logic [WIDTH-1:0] interval_q, interval_d;
    logic [WIDTH-1:0] match_1_q, match_1_d;
    logic [WIDTH-1:0] match_2_q, match_2_d;
    logic [WIDTH-1:0] match_3_q, match_3_d;
    logic             interval_intr_q, interval_intr_d;
    logic [3:1]       match_intr_q, match_intr_d;
    logic             overflow_intr_q, overflow_intr_d;
    logic             restart_q, restart_d;

    logic             restart_req;
    logic             tick;
    logic [WIDTH-1:0] cnt_next;
    logic             wrap_int;
    logic             wrap_ovf;
    logic [WIDTH-1:0] restart_val;

    always_comb begin
        cnt_next = counter_q;
        wrap_int = 1'b0;
        wrap_ovf = 1'b0;
        if (!ctrl_q[2]) begin
            if (ctrl_q[1] && counter_q == interval_q) begin
                cnt_next = '0;
                wrap_int = 1'b1;
            end else if (counter_q == ALL_ONES) begin
                cnt_next = '0;
                wrap_ovf = 1'b1;
            end else begin
                cnt_next = counter_q + 1'b1;
            end
        end else begin
            if (counter_q == '0 && ctrl_q[1]) begin
                cnt_next = interval_q;
                wrap_int = 1'b1;
            end else if (counter_q == '0) begin
                cnt_next = ALL_ONES;
                wrap_ovf = 1'b1;
            end else begin
                cnt_next = counter_q - 1'b1;
            end
        end
    end

    always_comb begin
        restart_req = cntr_ctrl_reg_sel28 & pwdata28[4];
        tick        = count_en28 & ~ctrl_q[0] & ~restart_req;

        // Restart direction follows the bits written alongside it
        if (!pwdata28[2])
            restart_val = '0;
        else if (pwdata28[1])
            restart_val = interval_q;
        else
            restart_val = ALL_ONES;

        ctrl_d     = cntr_ctrl_reg_sel28 ? pwdata28[3:0] : ctrl_q;
        interval_d = interval_reg_sel28 ? pwdata28 : interval_q;
        match_1_d  = match_reg_sel28[0] ? pwdata28 : match_1_q;
        match_2_d  = match_reg_sel28[1] ? pwdata28 : match_2_q;
        match_3_d  = match_reg_sel28[2] ? pwdata28 : match_3_q;

        counter_d = counter_q;
        if (restart_req)
            counter_d = restart_val;
        else if (tick)
            counter_d = cnt_next;

        interval_intr_d = tick & wrap_int;
        overflow_intr_d = tick & wrap_ovf;
        match_intr_d[1] = tick & ctrl_q[3] & (cnt_next == match_1_q);
        match_intr_d[2] = tick & ctrl_q[3] & (cnt_next == match_2_q);
        match_intr_d[3] = tick & ctrl_q[3] & (cnt_next == match_3_q);
        restart_d       = restart_req;
    end

    always_ff @(posedge pclk28 or posedge p_reset28) begin
        if (p_reset28) begin
            ctrl_q          <= 4'b0001;
            counter_q       <= '0;
            interval_q      <= '0;
            match_1_q       <= '0;
            match_2_q       <= '0;
            match_3_q       <= '0;
            interval_intr_q <= 1'b0;
            match_intr_q    <= '0;
            overflow_intr_q <= 1'b0;
            restart_q       <= 1'b0;
        end else begin
            ctrl_q          <= ctrl_d;
            counter_q       <= counter_d;
            interval_q      <= interval_d;
            match_1_q       <= match_1_d;
            match_2_q       <= match_2_d;
            match_3_q       <= match_3_d;
            interval_intr_q <= interval_intr_d;
            match_intr_q    <= match_intr_d;
            overflow_intr_q <= overflow_intr_d;
            restart_q       <= restart_d;
        end
    end

    assign counter_val_out28   = counter_q;
    assign cntr_ctrl_reg_out28 = {1'b0, ctrl_q};
    assign interval_reg_out28  = interval_q;
    assign match_1_reg_out28   = match_1_q;
    assign match_2_reg_out28   = match_2_q;
    assign match_3_reg_out28   = match_3_q;
    assign interval_intr28     = interval_intr_q;
    assign match_intr28        = match_intr_q;
    assign overflow_intr28     = overflow_intr_q;
    assign restart28           = restart_q;

endmodule

// File: tb/tb_ttc_counter_lite28.sv
// tb/tb_ttc_counter_lite28.sv - randomized self-checking bench for ttc_counter_lite28
module tb_ttc_counter_lite28;

    localparam int    W    = 16;
    localparam longint MOD = longint'(1) << W;
    localparam longint MAX = MOD - 1;

    logic          pclk28 = 1'b0;
    logic          p_reset28;
    logic [W-1:0]  pwdata28;
    logic          cntr_ctrl_reg_sel28;
    logic          interval_reg_sel28;
    logic [2:0]    match_reg_sel28;
    logic          count_en28;
    logic [W-1:0]  counter_val_out28;
    logic [4:0]    cntr_ctrl_reg_out28;
    logic [W-1:0]  interval_reg_out28;
    logic [W-1:0]  match_1_reg_out28;
    logic [W-1:0]  match_2_reg_out28;
    logic [W-1:0]  match_3_reg_out28;
    logic          interval_intr28;
    logic [3:1]    match_intr28;
    logic          overflow_intr28;
    logic          restart28;

    ttc_counter_lite28 #(.WIDTH(W)) dut (
        .pclk28              (pclk28),
        .p_reset28           (p_reset28),
        .pwdata28            (pwdata28),
        .cntr_ctrl_reg_sel28 (cntr_ctrl_reg_sel28),
        .interval_reg_sel28  (interval_reg_sel28),
        .match_reg_sel28     (match_reg_sel28),
        .count_en28          (count_en28),
        .counter_val_out28   (counter_val_out28),
        .cntr_ctrl_reg_out28 (cntr_ctrl_reg_out28),
        .interval_reg_out28  (interval_reg_out28),
        .match_1_reg_out28   (match_1_reg_out28),
        .match_2_reg_out28   (match_2_reg_out28),
        .match_3_reg_out28   (match_3_reg_out28),
        .interval_intr28     (interval_intr28),
        .match_intr28        (match_intr28),
        .overflow_intr28     (overflow_intr28),
        .restart28           (restart28)
    );

    always #5 pclk28 = ~pclk28;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state as plain numbers
    longint m_cnt, m_int;
    longint m_match [1:3];
    bit     m_dis, m_intv, m_down, m_men;
    bit     m_pi, m_po, m_pr;
    bit     m_pm [1:3];

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_int = 0;
        m_dis = 1; m_intv = 0; m_down = 0; m_men = 0;
        m_pi = 0; m_po = 0; m_pr = 0;
        for (int i = 1; i <= 3; i++) begin m_match[i] = 0; m_pm[i] = 0; end
    endtask

    task automatic model_step(input bit csel, input bit isel, input bit [2:0] msel,
                              input longint wd, input bit en);
        bit     restart, tick;
        longint nxt;
        bit     hit_i, hit_o;
        restart = csel && wd[4];
        tick    = en && !m_dis && !restart;
        hit_i = 0; hit_o = 0;
        if (!m_down) begin
            if (m_intv && m_cnt == m_int) begin nxt = 0; hit_i = 1; end
            else begin
                nxt = (m_cnt + 1) % MOD;
                hit_o = (m_cnt == MAX);
            end
        end else begin
            if (m_cnt == 0) begin
                nxt = m_intv ? m_int : MAX;
                hit_i = m_intv; hit_o = !m_intv;
            end else nxt = m_cnt - 1;
        end
        m_pi = tick && hit_i;
        m_po = tick && hit_o;
        m_pr = restart;
        for (int i = 1; i <= 3; i++) m_pm[i] = tick && m_men && (nxt == m_match[i]);
        if (restart) m_cnt = !wd[2] ? 0 : (wd[1] ? m_int : MAX);
        else if (tick) m_cnt = nxt;
        if (csel) begin m_dis = wd[0]; m_intv = wd[1]; m_down = wd[2]; m_men = wd[3]; end
        if (isel) m_int = wd;
        for (int i = 1; i <= 3; i++) if (msel[i-1]) m_match[i] = wd;
    endtask

    task automatic compare_all();
        check("count", counter_val_out28, m_cnt);
        check("ctrl", cntr_ctrl_reg_out28, {m_men, m_down, m_intv, m_dis});
        check("interval_reg", interval_reg_out28, m_int);
        check("match1_reg", match_1_reg_out28, m_match[1]);
        check("match2_reg", match_2_reg_out28, m_match[2]);
        check("match3_reg", match_3_reg_out28, m_match[3]);
        check("interval_intr", interval_intr28, m_pi);
        check("overflow_intr", overflow_intr28, m_po);
        check("match_intr", match_intr28, {m_pm[3], m_pm[2], m_pm[1]});
        check("restart", restart28, m_pr);
    endtask

    // Drives one cycle from a negedge, steps the model at the posedge, compares at the next negedge
    task automatic cyc(input bit csel, input bit isel, input bit [2:0] msel,
                       input longint wd, input bit en);
        cntr_ctrl_reg_sel28 = csel;
        interval_reg_sel28  = isel;
        match_reg_sel28     = msel;
        pwdata28            = W'(wd);
        count_en28          = en;
        @(posedge pclk28);
        model_step(csel, isel, msel, wd, en);
        @(negedge pclk28);
        compare_all();
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 3'b000, 0, 1);
    endtask

    initial begin
        p_reset28 = 1'b1;
        pwdata28 = '0; cntr_ctrl_reg_sel28 = 0; interval_reg_sel28 = 0;
        match_reg_sel28 = '0; count_en28 = 0;
        model_reset();
        repeat (2) @(negedge pclk28);
        p_reset28 = 1'b0;
        check("reset_count", counter_val_out28, 0);
        check("reset_ctrl", cntr_ctrl_reg_out28, 5'b00001);
        compare_all();

        // Disabled after reset: ticks ignored
        tick_n(2);
        check("disabled_hold", counter_val_out28, 0);

        // Free-running up count
        cyc(1, 0, 3'b000, 5'b00000, 0);
        for (int i = 1; i <= 5; i++) begin
            tick_n(1);
            check("up_seq", counter_val_out28, i);
        end

        // Up/interval with interval=3
        cyc(0, 1, 3'b000, 3, 0);
        cyc(1, 0, 3'b000, 5'b10010, 0);
        check("restart_up_load", counter_val_out28, 0);
        for (int i = 1; i <= 4; i++) begin
            tick_n(1);
            check("intv_seq", counter_val_out28, i % 4);
            check("intv_pulse", interval_intr28, i == 4);
        end

        // Down free-running restart to all-ones, then step to FFFE and count up with en 1,0,1
        cyc(1, 0, 3'b000, 5'b10100, 0);
        check("restart_down_free", counter_val_out28, 16'hFFFF);
        tick_n(1);
        cyc(1, 0, 3'b000, 5'b00000, 0);
        check("at_fffe", counter_val_out28, 16'hFFFE);
        cyc(0, 0, 3'b000, 0, 1);
        cyc(0, 0, 3'b000, 0, 0);
        check("held_ffff", counter_val_out28, 16'hFFFF);
        check("held_no_ovf", overflow_intr28, 0);
        cyc(0, 0, 3'b000, 0, 1);
        check("wrap_zero", counter_val_out28, 0);
        check("wrap_ovf", overflow_intr28, 1);

        // Down/interval with matches 1 and 3 at value 1
        cyc(0, 1, 3'b000, 2, 0);
        cyc(0, 0, 3'b101, 1, 0);
        cyc(1, 0, 3'b000, 5'b01110, 0);
        tick_n(2);
        check("down_match_cnt", counter_val_out28, 1);
        check("down_match_bits", match_intr28, 3'b101);
        tick_n(2);
        check("down_reload", counter_val_out28, 2);
        check("down_reload_intr", interval_intr28, 1);

        // Restart overriding a coincident tick at count 7
        cyc(1, 0, 3'b000, 5'b10000, 0);
        tick_n(7);
        check("at_seven", counter_val_out28, 7);
        cyc(1, 0, 3'b000, 5'b10000, 1);
        check("restart_cnt", counter_val_out28, 0);
        check("restart_pulse", restart28, 1);
        check("restart_ctrl4", cntr_ctrl_reg_out28[4], 0);
        tick_n(1);
        check("after_restart", counter_val_out28, 1);

        // Asynchronous reset mid-count at 9
        tick_n(8);
        check("at_nine", counter_val_out28, 9);
        #2 p_reset28 = 1'b1;
        #1;
        check("async_rst_cnt", counter_val_out28, 0);
        check("async_rst_ctrl", cntr_ctrl_reg_out28, 5'b00001);
        model_reset();
        @(negedge pclk28);
        p_reset28 = 1'b0;
        tick_n(3);
        check("post_rst_hold", counter_val_out28, 0);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            int     r;
            bit     cs, is;
            bit [2:0] ms;
            longint wd;
            r  = $urandom_range(0, 99);
            cs = (r < 5);
            is = (r >= 5 && r < 9);
            ms = (r >= 9 && r < 13) ? 3'($urandom_range(1, 7)) : 3'b000;
            if (cs) begin
                wd = longint'($urandom_range(0, 31));
                if ($urandom_range(0, 3) != 0) wd[0] = 0;
            end else if ($urandom_range(0, 1) == 0) begin
                wd = longint'($urandom_range(0, 20));
            end else begin
                wd = longint'($urandom) & MAX;
            end
            cyc(cs, is, ms, wd, $urandom_range(0, 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
